ps2_player_decoder: RTL and testbench

PS2_PLAYER_DECODER -- requirements
Module: ps2_player_decoder

---
 rtl/ps2_pkg.sv | 40 ++++
 rtl/ps2_frame_rx.sv | 82 ++++++++
 rtl/ps2_player_decoder.sv | 99 +++++++++
 tb/tb_ps2_player_decoder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types, constants and the default key map for the PS/2 player decoder.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_BASE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } dec_state_t;

   localparam logic [7:0] CODE_EXT    = 8'hE0;
   localparam logic [7:0] CODE_BRK    = 8'hF0;
   localparam int         FRAME_BITS  = 11;
   localparam int         MAP_PLAYERS = 4;
   localparam int         MAP_KEYS    = 5;

   // F0 is always consumed as a prefix, so it can never reach the lookup.
   localparam logic [8:0] MAP_UNUSED = {1'b0, CODE_BRK};

   localparam logic [8:0] KEY_MAP [0:MAP_PLAYERS*MAP_KEYS-1] = '{
      9'h01D, 9'h01C, 9'h01B, 9'h023, 9'h029,
      9'h175, 9'h16B, 9'h172, 9'h174, 9'h15A,
      MAP_UNUSED, MAP_UNUSED, MAP_UNUSED, MAP_UNUSED, MAP_UNUSED,
      MAP_UNUSED, MAP_UNUSED, MAP_UNUSED, MAP_UNUSED, MAP_UNUSED
   };

   function automatic logic [8:0] map_entry(input int p, input int k);
      if (p < MAP_PLAYERS && k < MAP_KEYS) begin
         return KEY_MAP[p*MAP_KEYS + k];
      end else begin
         return MAP_UNUSED;
      end
   endfunction

   // Data byte plus parity bit must hold an odd number of ones.
   function automatic logic odd_parity_ok(input logic [8:0] bits);
      return ^bits;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronisers, 11-bit framing, odd-parity and stop checks, and
// mid-frame timeout. Outputs are single-cycle strobes decoded from registered state.
module ps2_frame_rx
   import ps2_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       keyb_clk,
   input  logic       kdata,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       err
);

   localparam int         TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic [SYNC_STAGES-1:0] kclk_sync_r;
   logic [SYNC_STAGES-1:0] kdat_sync_r;
   logic                   kclk_prev_r;
   logic [3:0]             bit_cnt_r;
   logic [8:0]             shift_r;
   logic [TW-1:0]          tmo_cnt_r;

   logic fall_s, data_s, busy_s, last_bit_s, timeout_s, frame_ok_s, frame_bad_s;

   // Synchronisers idle high so reset never fabricates a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_sync_r <= '1;
         kdat_sync_r <= '1;
         kclk_prev_r <= 1'b1;
      end else begin
         kclk_sync_r <= {kclk_sync_r[SYNC_STAGES-2:0], keyb_clk};
         kdat_sync_r <= {kdat_sync_r[SYNC_STAGES-2:0], kdata};
         kclk_prev_r <= kclk_sync_r[SYNC_STAGES-1];
      end
   end

   assign fall_s      = kclk_prev_r & ~kclk_sync_r[SYNC_STAGES-1];
   assign data_s      = kdat_sync_r[SYNC_STAGES-1];
   assign busy_s      = (bit_cnt_r != 4'd0);
   assign last_bit_s  = (bit_cnt_r == LAST_BIT);
   assign timeout_s   = busy_s & ~fall_s & (tmo_cnt_r == TMO_LAST);
   assign frame_ok_s  = fall_s & last_bit_s & data_s & odd_parity_ok(shift_r);
   assign frame_bad_s = fall_s & last_bit_s & ~(data_s & odd_parity_ok(shift_r));

   assign rx_byte    = shift_r[7:0];
   assign byte_valid = frame_ok_s;
   assign err        = frame_bad_s | timeout_s;

   // Bit counter 0 means idle; 1..9 shift data and parity, 10 samples the stop bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt_r <= 4'd0;
         shift_r   <= 9'd0;
         tmo_cnt_r <= '0;
      end else if (fall_s) begin
         tmo_cnt_r <= '0;
         if (!busy_s) begin
            bit_cnt_r <= data_s ? 4'd0 : 4'd1;
         end else if (last_bit_s) begin
            bit_cnt_r <= 4'd0;
         end else begin
            shift_r   <= {data_s, shift_r[8:1]};
            bit_cnt_r <= bit_cnt_r + 4'd1;
         end
      end else if (timeout_s) begin
         bit_cnt_r <= 4'd0;
         tmo_cnt_r <= '0;
      end else if (busy_s) begin
         tmo_cnt_r <= tmo_cnt_r + TW'(1);
      end else begin
         tmo_cnt_r <= '0;
      end
   end

endmodule

// File: rtl/ps2_player_decoder.sv
// PS/2 keyboard to per-player held-key flags: prefix-tracking FSM and key-map lookup on
// top of the frame receiver.
module ps2_player_decoder
   import ps2_pkg::*;
#(
   parameter int NUM_PLAYERS     = 2,
   parameter int KEYS_PER_PLAYER = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int TIMEOUT_CYCLES  = 2500
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   keyb_clk,
   input  logic                                   kdata,
   output logic [NUM_PLAYERS*KEYS_PER_PLAYER-1:0] pkeys,
   output logic                                   code_valid,
   output logic                                   frame_err,
   output logic [7:0]                             debug_leds
);

   localparam int NK = NUM_PLAYERS * KEYS_PER_PLAYER;

   logic [7:0]  rx_byte_s;
   logic        byte_valid_s, err_s;
   dec_state_t  state_r, next_state_s;
   logic        ext_s, brk_s, is_prefix_s;
   logic [NK-1:0] hit_s, pkeys_next_s;

   ps2_frame_rx #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .keyb_clk   (keyb_clk),
      .kdata      (kdata),
      .rx_byte    (rx_byte_s),
      .byte_valid (byte_valid_s),
      .err        (err_s)
   );

   // Prefix tracking and key-map lookup for the byte completing this cycle.
   always_comb begin
      next_state_s = state_r;
      pkeys_next_s = pkeys;
      hit_s        = '0;
      ext_s        = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
      brk_s        = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
      is_prefix_s  = (rx_byte_s == CODE_EXT) || (rx_byte_s == CODE_BRK);

      for (int p = 0; p < NUM_PLAYERS; p++) begin
         for (int k = 0; k < KEYS_PER_PLAYER; k++) begin
            hit_s[p*KEYS_PER_PLAYER + k] = ({ext_s, rx_byte_s} == map_entry(p, k));
         end
      end

      if (byte_valid_s) begin
         // A prefix always restarts from BASE, except F0 directly after E0.
         case (rx_byte_s)
            CODE_EXT: next_state_s = ST_EXT;
            CODE_BRK: next_state_s = (state_r == ST_EXT) ? ST_EXT_BRK : ST_BRK;
            default:  next_state_s = ST_BASE;
         endcase
         if (!is_prefix_s) begin
            for (int i = 0; i < NK; i++) begin
               if (hit_s[i]) begin
                  pkeys_next_s[i] = ~brk_s;
               end else begin
                  pkeys_next_s[i] = pkeys[i];
               end
            end
         end else begin
            pkeys_next_s = pkeys;
         end
      end else begin
         next_state_s = state_r;
      end
   end

   // Registered outputs; all byte effects land together with code_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_BASE;
         pkeys      <= '0;
         debug_leds <= 8'd0;
         code_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         state_r    <= next_state_s;
         pkeys      <= pkeys_next_s;
         code_valid <= byte_valid_s;
         frame_err  <= err_s;
         if (byte_valid_s) begin
            debug_leds <= rx_byte_s;
         end
      end
   end

endmodule

// File: tb/tb_ps2_player_decoder.sv
// Directed bench for ps2_player_decoder: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_player_decoder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       keyb_clk = 1'b1;
   logic       kdata = 1'b1;
   logic [9:0] pkeys;
   logic       code_valid, frame_err;
   logic [7:0] debug_leds;

   int errors = 0;
   int checks = 0;
   int cv_cnt = 0;
   int fe_cnt = 0;
   int cv0, fe0;

   ps2_player_decoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .keyb_clk   (keyb_clk),
      .kdata      (kdata),
      .pkeys      (pkeys),
      .code_valid (code_valid),
      .frame_err  (frame_err),
      .debug_leds (debug_leds)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled on the inactive edge; one count per high cycle.
   always @(negedge clk) begin
      if (code_valid === 1'b1) cv_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      kdata = b;
      #40;
      keyb_clk = 1'b0;
      #40;
      keyb_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par_ok, input logic stop);
      logic p;
      p = par_ok ? ~(^b) : (^b);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      send_bit(stop);
      kdata = 1'b1;
      #100;
   endtask

   initial begin
      #23;
      check("rst_pkeys", 32'(pkeys), 32'h0);
      check("rst_leds", 32'(debug_leds), 32'h0);
      check("rst_cv", 32'(code_valid), 32'h0);
      check("rst_fe", 32'(frame_err), 32'h0);
      rst_n = 1'b1;
      #50;

      // 75 unmapped without E0
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h75, 1'b1, 1'b1);
      check("b75_cv", 32'(cv_cnt - cv0), 32'd1);
      check("b75_fe", 32'(fe_cnt - fe0), 32'd0);
      check("b75_leds", 32'(debug_leds), 32'h75);
      check("b75_pkeys", 32'(pkeys), 32'h0);

      // make / break of player 0 W
      send_frame(8'h1D, 1'b1, 1'b1);
      check("make_1d", 32'(pkeys), 32'h001);
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h1D, 1'b1, 1'b1);
      check("break_1d", 32'(pkeys), 32'h000);

      // extended key for player 1 while player 0 holds W
      send_frame(8'h1D, 1'b1, 1'b1);
      cv0 = cv_cnt;
      send_frame(8'hE0, 1'b1, 1'b1);
      send_frame(8'h75, 1'b1, 1'b1);
      check("ext_cv", 32'(cv_cnt - cv0), 32'd2);
      check("make_e075", 32'(pkeys), 32'h021);
      send_frame(8'hE0, 1'b1, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h75, 1'b1, 1'b1);
      check("break_e075", 32'(pkeys), 32'h001);
      check("leds_75", 32'(debug_leds), 32'h75);

      // parity error
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h1D, 1'b0, 1'b1);
      check("par_fe", 32'(fe_cnt - fe0), 32'd1);
      check("par_cv", 32'(cv_cnt - cv0), 32'd0);
      check("par_pkeys", 32'(pkeys), 32'h001);
      check("par_leds", 32'(debug_leds), 32'h75);

      // stop bit error
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h1C, 1'b1, 1'b0);
      check("stop_fe", 32'(fe_cnt - fe0), 32'd1);
      check("stop_cv", 32'(cv_cnt - cv0), 32'd0);
      check("stop_pkeys", 32'(pkeys), 32'h001);
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h1D, 1'b1, 1'b1);
      check("clr_1d", 32'(pkeys), 32'h000);

      // start bit sampled high is ignored
      fe0 = fe_cnt; cv0 = cv_cnt;
      send_bit(1'b1);
      #100;
      check("start1_fe", 32'(fe_cnt - fe0), 32'd0);
      send_frame(8'h1B, 1'b1, 1'b1);
      check("start1_cv", 32'(cv_cnt - cv0), 32'd1);
      check("make_1b", 32'(pkeys), 32'h004);

      // partial frame timeout
      fe0 = fe_cnt; cv0 = cv_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      kdata = 1'b1;
      #26000;
      check("tmo_fe", 32'(fe_cnt - fe0), 32'd1);
      check("tmo_cv", 32'(cv_cnt - cv0), 32'd0);
      send_frame(8'h1C, 1'b1, 1'b1);
      check("tmo_1c", 32'(pkeys), 32'h006);

      // mid-frame reset
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h1B, 1'b1, 1'b1);
      send_frame(8'hF0, 1'b1, 1'b1);
      send_frame(8'h1C, 1'b1, 1'b1);
      send_frame(8'h1D, 1'b1, 1'b1);
      check("pre_rst", 32'(pkeys), 32'h001);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      #13;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pkeys", 32'(pkeys), 32'h0);
      check("mid_rst_leds", 32'(debug_leds), 32'h0);
      check("mid_rst_cv", 32'(code_valid), 32'h0);
      check("mid_rst_fe", 32'(frame_err), 32'h0);
      kdata = 1'b1;
      #20;
      rst_n = 1'b1;
      #50;
      cv0 = cv_cnt; fe0 = fe_cnt;
      send_frame(8'h29, 1'b1, 1'b1);
      check("post_rst_pkeys", 32'(pkeys), 32'h010);
      check("post_rst_leds", 32'(debug_leds), 32'h29);
      check("post_rst_cv", 32'(cv_cnt - cv0), 32'd1);
      check("post_rst_fe", 32'(fe_cnt - fe0), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
